// File: rtl/invaders_pkg.sv
// Shared formation geometry and march-controller state encoding for the invaders slice.
package invaders_pkg;

  localparam int ALIEN_W   = 30;
  localparam int ALIEN_H   = 20;
  localparam int ALIEN_XSP = 10;
  localparam int ALIEN_YSP = 10;
  localparam int NUM_COLS  = 10;
  localparam int NUM_ROWS  = 5;

  typedef logic [1:0] march_state_t;

  localparam march_state_t ST_MOVE_R = 2'd0;
  localparam march_state_t ST_MOVE_L = 2'd1;
  localparam march_state_t ST_LANDED = 2'd2;

endpackage

// File: rtl/alien_march_ctrl_if.sv
// Bundle between the game side (master) and the alien march controller (slave).
interface alien_march_ctrl_if;
  import invaders_pkg::*;

  // FrameTick is a one-cycle strobe with no ready: the controller samples it
  // every cycle and never back-pressures; all other signals are levels.
  logic                             FrameTick;
  logic                             Pause;
  logic [NUM_ROWS*NUM_COLS-1:0]     Aliens_Grid;
  logic [8:0]                       AliensRow;
  logic [9:0]                       AliensCol;
  logic                             StepPulse;
  logic                             Landed;
  logic                             Cleared;
  march_state_t                     State;
  logic [5:0]                       FrameCnt;

  modport master (
    output FrameTick, Pause, Aliens_Grid,
    input  AliensRow, AliensCol, StepPulse, Landed, Cleared, State, FrameCnt
  );

  modport slave (
    input  FrameTick, Pause, Aliens_Grid,
    output AliensRow, AliensCol, StepPulse, Landed, Cleared, State, FrameCnt
  );

endinterface

// File: rtl/grid_extents.sv
// Combinational live-alien extents: leftmost/rightmost live column, lowest live row, live count.
module grid_extents
  import invaders_pkg::*;
(
  input  logic [NUM_ROWS*NUM_COLS-1:0] Grid,
  output logic [3:0]                   Lc,
  output logic [3:0]                   Rc,
  output logic [2:0]                   Br,
  output logic [5:0]                   LiveCount
);

  logic [NUM_COLS-1:0] colAny;
  logic [NUM_ROWS-1:0] rowAny;

  always_comb begin
    colAny    = '0;
    rowAny    = '0;
    LiveCount = '0;
    Lc        = '0;
    Rc        = '0;
    Br        = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (Grid[r*NUM_COLS + c]) begin
          colAny[c] = 1'b1;
          rowAny[r] = 1'b1;
        end
        LiveCount = LiveCount + 6'(Grid[r*NUM_COLS + c]);
      end
    end
    // Descending scan so the last hit is the lowest-numbered live column.
    for (int c = NUM_COLS - 1; c >= 0; c--)
      if (colAny[c]) Lc = 4'(c);
    for (int c = 0; c < NUM_COLS; c++)
      if (colAny[c]) Rc = 4'(c);
    for (int r = 0; r < NUM_ROWS; r++)
      if (rowAny[r]) Br = 3'(r);
  end

endmodule

// File: rtl/alien_march_ctrl.sv
// Alien formation march controller: frame-paced stepping, edge bounce/drop, speed-up and landing.
module alien_march_ctrl
  import invaders_pkg::*;
#(
  parameter int START_COL  = 20,
  parameter int START_ROW  = 40,
  parameter int STEP_X     = 8,
  parameter int DROP_Y     = 16,
  parameter int SCREEN_W   = 640,
  parameter int LAND_ROW   = 440,
  parameter int MIN_PERIOD = 2
) (
  input logic               Clk,
  input logic               Reset,
  alien_march_ctrl_if.slave bus
);

  logic [3:0]   lc, rc;
  logic [2:0]   br;
  logic [5:0]   liveCount;
  logic [5:0]   period;
  logic [8:0]   rowReg;
  logic [9:0]   colReg;
  logic [5:0]   frameCnt;
  logic         stepPulse;
  logic         landed;
  march_state_t state;

  logic [10:0]  colExt, rowExt;
  logic         cleared, hitRight, hitLeft, landHit, tickOk;

  grid_extents uExtents (
    .Grid      (bus.Aliens_Grid),
    .Lc        (lc),
    .Rc        (rc),
    .Br        (br),
    .LiveCount (liveCount)
  );

  // Edge and landing tests are evaluated at 11 bits so none of the sums can wrap.
  assign colExt   = {1'b0, colReg};
  assign rowExt   = {2'b0, rowReg};
  assign period   = 6'(MIN_PERIOD) + (liveCount >> 2);
  assign cleared  = (bus.Aliens_Grid == '0);
  assign hitRight = (colExt + 11'(STEP_X) + 11'(rc) * 11'(ALIEN_W + ALIEN_XSP) + 11'(ALIEN_W))
                    > 11'(SCREEN_W);
  assign hitLeft  = (colExt + 11'(lc) * 11'(ALIEN_W + ALIEN_XSP)) < 11'(STEP_X);
  assign landHit  = (rowExt + 11'(br) * 11'(ALIEN_H + ALIEN_YSP) + 11'(ALIEN_H)) >= 11'(LAND_ROW);
  assign tickOk   = bus.FrameTick && !bus.Pause && !cleared && (state != ST_LANDED);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rowReg    <= 9'(START_ROW);
      colReg    <= 10'(START_COL);
      state     <= ST_MOVE_R;
      frameCnt  <= '0;
      stepPulse <= 1'b0;
      landed    <= 1'b0;
    end else begin
      stepPulse <= 1'b0;
      if (!cleared && landHit) begin
        landed <= 1'b1;
        state  <= ST_LANDED;
      end else if (tickOk) begin
        // >= rather than == so a period that shrinks mid-count fires at once.
        if (frameCnt >= period - 6'd1) begin
          frameCnt  <= '0;
          stepPulse <= 1'b1;
          if (state == ST_MOVE_R) begin
            if (hitRight) begin
              rowReg <= rowReg + 9'(DROP_Y);
              state  <= ST_MOVE_L;
            end else begin
              colReg <= colReg + 10'(STEP_X);
            end
          end else begin
            if (hitLeft) begin
              rowReg <= rowReg + 9'(DROP_Y);
              state  <= ST_MOVE_R;
            end else begin
              colReg <= colReg - 10'(STEP_X);
            end
          end
        end else begin
          frameCnt <= frameCnt + 6'd1;
        end
      end
    end
  end

  assign bus.AliensRow = rowReg;
  assign bus.AliensCol = colReg;
  assign bus.StepPulse = stepPulse;
  assign bus.Landed    = landed;
  assign bus.Cleared   = cleared;
  assign bus.State     = state;
  assign bus.FrameCnt  = frameCnt;

endmodule
